// File: rtl/alu_decoder.sv
// RV32I instruction field/immediate decoder plus a registered single-cycle ALU.
// Optional macro ALU_DECODER_ALT_EN enables the alt bit (SUB for func 000, SRA for func 101).
module alu_decoder #(
  parameter logic [31:0] ALU_RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        illegal,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [2:0]  func,
  input  logic        alt,
  output logic [31:0] result
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SLL  = 3'b001;
  localparam logic [2:0] FN_SLT  = 3'b010;
  localparam logic [2:0] FN_SLTU = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_SR   = 3'b101;
  localparam logic [2:0] FN_OR   = 3'b110;
  localparam logic [2:0] FN_AND  = 3'b111;

  // Field extraction: pure wiring, independent of clk and reset.
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  always_comb begin
    imm     = 32'h0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_OP:
        imm = 32'h0;
      default: begin
        imm     = 32'h0;
        illegal = 1'b1;
      end
    endcase
  end

  // alt is only meaningful when the optional feature is compiled in.
  logic use_alt;
`ifdef ALU_DECODER_ALT_EN
  assign use_alt = alt;
`else
  assign use_alt = 1'b0;
  logic unused_alt;
  assign unused_alt = alt;
`endif

  logic [4:0]  shamt;
  logic [31:0] alu_next;

  assign shamt = rhs[4:0];

  always_comb begin
    alu_next = 32'h0;
    case (func)
      FN_ADD:  alu_next = use_alt ? (lhs - rhs) : (lhs + rhs);
      FN_SLL:  alu_next = lhs << shamt;
      FN_SLT:  alu_next = ($signed(lhs) < $signed(rhs)) ? 32'h1 : 32'h0;
      FN_SLTU: alu_next = (lhs < rhs) ? 32'h1 : 32'h0;
      FN_XOR:  alu_next = lhs ^ rhs;
      FN_SR:   alu_next = use_alt ? 32'($signed(lhs) >>> shamt) : (lhs >> shamt);
      FN_OR:   alu_next = lhs | rhs;
      FN_AND:  alu_next = lhs & rhs;
      default: alu_next = 32'h0;
    endcase
  end

  // No handshake: operands sampled every rising edge, result valid one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result <= ALU_RESET_VAL;
    else        result <= alu_next;
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Directed self-checking bench for alu_decoder: decoder fields, ALU ops, latency and reset.
`timescale 1ns/1ps
module tb_alu_decoder;

  localparam logic [31:0] RST_VAL = 32'hA5A5_5A5A;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [2:0]  func;
  logic        alt;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  alu_decoder #(.ALU_RESET_VAL(RST_VAL)) dut (
    .clk(clk), .reset(reset), .inst(inst),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .illegal(illegal),
    .lhs(lhs), .rhs(rhs), .func(func), .alt(alt), .result(result)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply operands at the falling edge, return 1ns after the rising edge
  task automatic drive_alu(input logic [31:0] l, input logic [31:0] r,
                           input logic [2:0] f, input logic a);
    @(negedge clk);
    lhs = l; rhs = r; func = f; alt = a;
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [31:0] i);
    inst = i;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    checks++;
    if (result !== RST_VAL) begin
      errors++; $display("FAIL reset_val: result=%h expected=%h", result, RST_VAL);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_decode;
    set_inst(32'h00500093);
    checks++;
    if ({opcode, rd, funct3, rs1, imm, illegal} !== {7'h13, 5'd1, 3'd0, 5'd0, 32'h5, 1'b0}) begin
      errors++;
      $display("FAIL dec_addi: op=%h rd=%0d f3=%0d rs1=%0d imm=%h ill=%b expected 13/1/0/0/00000005/0",
               opcode, rd, funct3, rs1, imm, illegal);
    end
    set_inst(32'hFFF00093);
    checks++;
    if (imm !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dec_addi_neg: imm=%h expected=ffffffff", imm);
    end
    set_inst(32'h123450B7);
    checks++;
    if (imm !== 32'h1234_5000 || rd !== 5'd1 || illegal !== 1'b0) begin
      errors++; $display("FAIL dec_lui: imm=%h rd=%0d ill=%b expected 12345000/1/0", imm, rd, illegal);
    end
    set_inst(32'h0080006F);
    checks++;
    if (imm !== 32'h0000_0008) begin
      errors++; $display("FAIL dec_jal: imm=%h expected=00000008", imm);
    end
    set_inst(32'hFE000EE3);
    checks++;
    if (imm !== 32'hFFFF_FFFC || illegal !== 1'b0) begin
      errors++; $display("FAIL dec_branch: imm=%h ill=%b expected fffffffc/0", imm, illegal);
    end
    set_inst(32'hFE532E23);
    checks++;
    if (imm !== 32'hFFFF_FFFC || rs1 !== 5'd6 || rs2 !== 5'd5 || funct3 !== 3'd2) begin
      errors++; $display("FAIL dec_store: imm=%h rs1=%0d rs2=%0d f3=%0d expected fffffffc/6/5/2",
                         imm, rs1, rs2, funct3);
    end
    set_inst(32'h40B505B3);
    checks++;
    if ({funct7, rs2, rs1, rd, opcode, imm, illegal} !==
        {7'h20, 5'd11, 5'd10, 5'd11, 7'h33, 32'h0, 1'b0}) begin
      errors++; $display("FAIL dec_op: f7=%h rs2=%0d rs1=%0d rd=%0d op=%h imm=%h ill=%b expected 20/11/10/11/33/0/0",
                         funct7, rs2, rs1, rd, opcode, imm, illegal);
    end
    set_inst(32'h0000007F);
    checks++;
    if (illegal !== 1'b1 || imm !== 32'h0) begin
      errors++; $display("FAIL dec_illegal: ill=%b imm=%h expected 1/00000000", illegal, imm);
    end
  endtask

  task automatic test_add_sub;
    logic [31:0] exp_sub;
`ifdef ALU_DECODER_ALT_EN
    exp_sub = 32'd2;
`else
    exp_sub = 32'd8;
`endif
    drive_alu(32'd10, 32'd20, 3'b000, 1'b0);
    checks++;
    if (result !== 32'd30) begin
      errors++; $display("FAIL add: result=%h expected=0000001e", result);
    end
    @(negedge clk);
    lhs = 32'd5; rhs = 32'd3; func = 3'b000; alt = 1'b1;
    #1;
    checks++;
    if (result !== 32'd30) begin
      errors++; $display("FAIL latency_hold: result=%h expected=0000001e", result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== exp_sub) begin
      errors++; $display("FAIL add_alt: result=%h expected=%h", result, exp_sub);
    end
    drive_alu(32'hFFFF_FFFF, 32'd2, 3'b000, 1'b0);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL add_wrap: result=%h expected=00000001", result);
    end
  endtask

  task automatic test_shift_cmp;
    logic [31:0] exp_sra;
`ifdef ALU_DECODER_ALT_EN
    exp_sra = 32'hF800_0000;
`else
    exp_sra = 32'h0800_0000;
`endif
    drive_alu(32'h8000_0000, 32'd4, 3'b101, 1'b1);
    checks++;
    if (result !== exp_sra) begin
      errors++; $display("FAIL sr_alt: result=%h expected=%h", result, exp_sra);
    end
    drive_alu(32'h8000_0000, 32'd4, 3'b101, 1'b0);
    checks++;
    if (result !== 32'h0800_0000) begin
      errors++; $display("FAIL srl: result=%h expected=08000000", result);
    end
    drive_alu(32'h0000_0001, 32'hFFFF_FFE5, 3'b001, 1'b0);
    checks++;
    if (result !== 32'h0000_0020) begin
      errors++; $display("FAIL sll_shamt: result=%h expected=00000020", result);
    end
    drive_alu(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1);
    checks++;
    if (result !== 32'h1) begin
      errors++; $display("FAIL slt: result=%h expected=00000001", result);
    end
    drive_alu(32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0);
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL sltu: result=%h expected=00000000", result);
    end
    drive_alu(32'd1, 32'hFFFF_FFFF, 3'b011, 1'b0);
    checks++;
    if (result !== 32'h1) begin
      errors++; $display("FAIL sltu_true: result=%h expected=00000001", result);
    end
  endtask

  task automatic test_back_to_back;
    drive_alu(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b100, 1'b1);
    checks++;
    if (result !== 32'hFF00_EDCB) begin
      errors++; $display("FAIL xor: result=%h expected=ff00edcb", result);
    end
    drive_alu(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b110, 1'b1);
    checks++;
    if (result !== 32'hFFF0_FFFF) begin
      errors++; $display("FAIL or: result=%h expected=fff0ffff", result);
    end
    drive_alu(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b111, 1'b1);
    checks++;
    if (result !== 32'h00F0_1234) begin
      errors++; $display("FAIL and: result=%h expected=00f01234", result);
    end
  endtask

  task automatic test_reset_mid;
    drive_alu(32'd5, 32'd3, 3'b000, 1'b0);
    checks++;
    if (result !== 32'd8) begin
      errors++; $display("FAIL pre_reset: result=%h expected=00000008", result);
    end
    // assert reset between edges with a new op pending
    @(negedge clk);
    lhs = 32'd100; rhs = 32'd1; func = 3'b000; alt = 1'b0;
    #2;
    reset = 1'b0;
    inst = 32'h123450B7;
    #1;
    checks++;
    if (result !== RST_VAL) begin
      errors++; $display("FAIL reset_async: result=%h expected=%h", result, RST_VAL);
    end
    checks++;
    if (imm !== 32'h1234_5000 || opcode !== 7'h37) begin
      errors++; $display("FAIL dec_in_reset: imm=%h op=%h expected 12345000/37", imm, opcode);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== RST_VAL) begin
      errors++; $display("FAIL reset_discard: result=%h expected=%h", result, RST_VAL);
    end
    @(negedge clk);
    reset = 1'b1;
    lhs = 32'd7; rhs = 32'd6; func = 3'b111; alt = 1'b0;
    #1;
    checks++;
    if (result !== RST_VAL) begin
      errors++; $display("FAIL reset_release_hold: result=%h expected=%h", result, RST_VAL);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd6) begin
      errors++; $display("FAIL first_after_reset: result=%h expected=00000006", result);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst  = 32'h0;
    lhs   = 32'h0;
    rhs   = 32'h0;
    func  = 3'b000;
    alt   = 1'b0;
    #2;
    test_reset();
    test_decode();
    test_add_sub();
    test_shift_cmp();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 SHALL have parameter ALU_RESET_VAL, default 32'h0000_0000; the value `result` takes while reset is asserted.
REQ-002 SHALL have `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have `reset`, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have `inst`, input, 32 bits: RV32I instruction word to decode.
REQ-005 SHALL have `opcode`, output, 7 bits: inst[6:0].
REQ-006 SHALL have `rd`, output, 5 bits: inst[11:7].
REQ-007 SHALL have `funct3`, output, 3 bits: inst[14:12].
REQ-008 SHALL have `rs1`, output, 5 bits: inst[19:15].
REQ-009 SHALL have `rs2`, output, 5 bits: inst[24:20].
REQ-010 SHALL have `funct7`, output, 7 bits: inst[31:25].
REQ-011 SHALL have `imm`, output, 32 bits: decoded, sign-extended immediate.
REQ-012 SHALL have `illegal`, output, 1 bit: opcode is not one of the nine listed in REQ-014..REQ-019.
REQ-013 SHALL have ALU inputs `lhs` (input, 32 bits), `rhs` (input, 32 bits), `func` (input, 3 bits) and `alt` (input, 1 bit), and ALU output `result` (output, 32 bits, registered).

Function
REQ-014 Decoder outputs SHALL be purely combinational from `inst`, with no clock or reset dependency.
REQ-015 For LUI (0110111) and AUIPC (0010111), `imm` SHALL be {inst[31:12], 12'b0}.
REQ-016 For JAL (1101111), `imm` SHALL be sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
REQ-017 For JALR (1100111), LOAD (0000011) and OP_IM (0010011), `imm` SHALL be sext(inst[31:20]).
REQ-018 For STORE (0100011), `imm` SHALL be sext({inst[31:25], inst[11:7]}).
REQ-019 For BRANCH (1100011), `imm` SHALL be sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); for OP (0110011) `imm` SHALL be 0.
REQ-020 For any other opcode, `imm` SHALL be 0 and `illegal` SHALL be 1; otherwise `illegal` SHALL be 0.
REQ-021 ALU `func` SHALL select: 000 ADD/SUB, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-022 Shift amounts SHALL be rhs[4:0]; rhs[31:5] SHALL be ignored for shifts.
REQ-023 SLT/SLTU SHALL produce 32'h1 when true and 32'h0 when false.
REQ-024 ADD/SUB SHALL wrap modulo 2^32, with no carry or overflow output.
REQ-025 `result` SHALL be registered: inputs sampled at rising edge N appear on `result` after edge N; latency is exactly 1 cycle, a new operation is accepted every cycle, and there is no handshake.
REQ-026 `alt` SHALL affect only func 000 and func 101, as defined in REQ-033/REQ-034; for all other func values it SHALL be ignored.

Reset
REQ-027 While `reset` is 0, `result` SHALL be forced to ALU_RESET_VAL immediately, without waiting for a clock edge.
REQ-028 On the first rising edge after `reset` returns to 1, `result` SHALL load the ALU operation sampled at that edge.
REQ-029 Reset asserted mid-operation SHALL discard the pending result.
REQ-030 Decoder outputs SHALL be unaffected by `reset`.

Configuration
REQ-031 The macro ALU_DECODER_ALT_EN SHALL select whether `alt` is honoured.
REQ-032 With ALU_DECODER_ALT_EN undefined, `alt` SHALL be ignored: func 000 always ADD, func 101 always SRL.
REQ-033 With ALU_DECODER_ALT_EN defined and func 000: alt=1 SHALL select SUB (lhs - rhs); alt=0 SHALL select ADD.
REQ-034 With ALU_DECODER_ALT_EN defined and func 101: alt=1 SHALL select SRA (arithmetic right shift); alt=0 SHALL select SRL.

Verification
REQ-035 Decode: inst=32'h00500093 -> opcode=7'h13, rd=1, funct3=0, rs1=0, imm=32'h5, illegal=0; inst=32'hFFF00093 -> imm=32'hFFFFFFFF.
REQ-036 U/J decode: inst=32'h123450B7 -> imm=32'h12345000, rd=1; inst=32'h0080006F -> imm=32'h00000008.
REQ-037 B decode and illegal: inst=32'hFE000EE3 -> imm=32'hFFFFFFFC; inst=32'h0000007F -> illegal=1, imm=0.
REQ-038 ALU add/sub: lhs=5, rhs=3, func=000, alt=1 -> result=2 one edge later with ALU_DECODER_ALT_EN defined, 8 without it; result is unchanged before that edge.
REQ-039 Shift and compare: lhs=32'h80000000, rhs=4, func=101 -> result=32'hF8000000 (alt=1, macro defined) or 32'h08000000 (alt=0); lhs=32'hFFFFFFFF, rhs=1 -> SLT result=1, SLTU result=0.
REQ-040 Reset: with result=8, drive reset=0 between clock edges -> result=ALU_RESET_VAL immediately; release reset -> the next edge loads the ALU operation sampled at that edge.
